// File: rtl/approx_mult_pkg.sv
// Shared constants and elaboration-time helpers for the approximate multiplier.
// Masks and compensation are 64 bits wide, so W is limited to 32.
package approx_mult_pkg;

   localparam int STAGES = 3;

   // Kept-bit mask over y for multiplier row i; rows at or above L keep every bit.
   function automatic logic [63:0] row_mask(input int i, input int w, input int l, input int t);
      logic [63:0] m;
      m = '0;
      for (int j = 0; j < 64; j++) begin
         if (j < w && (i >= l || i + j >= t)) m[j] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [63:0] comp_val(input int t);
      return (t == 0) ? 64'd0 : (64'd1 << (t - 1));
   endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// Operand/result handshake bundle for approx_mult_pipe.
// master = producer/consumer side, slave = multiplier side.
interface approx_mult_pipe_if #(
   parameter int W     = 8,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     x;
   logic [W-1:0]     y;
   logic             exact;
   logic [TAG_W-1:0] tag_in;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   z;
   logic [TAG_W-1:0] tag_out;

   modport master (
      output in_valid, x, y, exact, tag_in, out_ready,
      input  in_ready, out_valid, z, tag_out
   );

   modport slave (
      input  in_valid, x, y, exact, tag_in, out_ready,
      output in_ready, out_valid, z, tag_out
   );
endinterface

// File: rtl/approx_lowrows.sv
// Combinational sum of the L low multiplier rows, truncated below column T unless exact.
// Zero latency; no handshake.
module approx_lowrows
   import approx_mult_pkg::*;
#(
   parameter int W = 8,
   parameter int L = 4,
   parameter int T = W - 1
) (
   input  logic [L-1:0]   x_lo,
   input  logic [W-1:0]   y,
   input  logic           exact,
   output logic [W+L-1:0] lo_sel
);
   localparam int LW = W + L;

   logic [W-1:0] row [L];

   for (genvar i = 0; i < L; i++) begin : g_row
      localparam logic [63:0] MASK = row_mask(i, W, L, T);
      assign row[i] = x_lo[i] ? (exact ? y : (y & MASK[W-1:0])) : '0;
   end

   always_comb begin
      logic [LW-1:0] acc;
      acc = '0;
      for (int i = 0; i < L; i++) begin
         acc = acc + (LW'(row[i]) << i);
      end
      lo_sel = acc;
   end
endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined exact/approximate unsigned multiplier, 3-cycle latency, 1/cycle; APPROX_COMP_EN adds 2^(T-1) bias.
// A held result (out_valid & !out_ready) freezes every stage and drops in_ready.
module approx_mult_pipe
   import approx_mult_pkg::*;
#(
   parameter int W     = 8,
   parameter int L     = 4,
   parameter int T     = W - 1,
   parameter int TAG_W = 4
) (
   input logic              clk,
   input logic              rst_n,
   approx_mult_pipe_if.slave bus
);
   localparam int HW = 2 * W - L;

`ifdef APPROX_COMP_EN
   localparam logic [63:0]    COMP64 = comp_val(T);
   localparam logic [2*W-1:0] COMP   = COMP64[2*W-1:0];
`else
   localparam logic [2*W-1:0] COMP = '0;
`endif

   logic             v1, v2, v3;
   logic [W-1:0]     x1, y1;
   logic             e1, e2;
   logic [TAG_W-1:0] tag1, tag2, tag3;
   logic [HW-1:0]    hi2, hi_d;
   logic [W+L-1:0]   lo2, lo_d;
   logic [2*W-1:0]   z3, z_d;
   logic             adv;

   assign adv = !v3 | bus.out_ready;

   assign hi_d = {{(W - L){1'b0}}, y1} * {{W{1'b0}}, x1[W-1:L]};

   approx_lowrows #(.W(W), .L(L), .T(T)) u_lowrows (
      .x_lo   (x1[L-1:0]),
      .y      (y1),
      .exact  (e1),
      .lo_sel (lo_d)
   );

   assign z_d = {hi2, {L{1'b0}}} + {{(W - L){1'b0}}, lo2} + (e2 ? '0 : COMP);

   // Single global enable: bubbles are kept, so a stall never reorders results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         x1   <= '0;
         y1   <= '0;
         e1   <= 1'b0;
         e2   <= 1'b0;
         tag1 <= '0;
         tag2 <= '0;
         tag3 <= '0;
         hi2  <= '0;
         lo2  <= '0;
         z3   <= '0;
      end else if (adv) begin
         v1   <= bus.in_valid;
         x1   <= bus.x;
         y1   <= bus.y;
         e1   <= bus.exact;
         tag1 <= bus.tag_in;
         v2   <= v1;
         hi2  <= hi_d;
         lo2  <= lo_d;
         e2   <= e1;
         tag2 <= tag1;
         v3   <= v2;
         z3   <= z_d;
         tag3 <= tag2;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = v3;
   assign bus.z         = z3;
   assign bus.tag_out   = tag3;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe at W=8, L=4, T=7: directed spec cases, stall, reset, random traffic.
module tb_approx_mult_pipe;
   import approx_mult_pkg::*;

   localparam int W     = 8;
   localparam int L     = 4;
   localparam int T     = 7;
   localparam int TAG_W = 4;

   typedef struct {
      logic [15:0] z;
      logic [3:0]  tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   n_ret = 0;
   exp_t exp_q[$];

   approx_mult_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();

   approx_mult_pipe #(.W(W), .L(L), .T(T), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", nm, obs, expv);
      end
   endtask

   // Reference: sum every partial-product bit the mode keeps.
   function automatic logic [15:0] ref_z(input logic [7:0] a, input logic [7:0] b, input logic e);
      int unsigned s;
      s = 0;
      for (int i = 0; i < W; i++)
         for (int j = 0; j < W; j++)
            if (a[i] && b[j] && (e || i >= L || i + j >= T)) s += (32'd1 << (i + j));
`ifdef APPROX_COMP_EN
      if (!e) s += 32'd64;
`endif
      return s[15:0];
   endfunction

   // Scoreboard: expected results enter at acceptance, leave at retirement.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'(bus.z), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("result_z", 32'(bus.z), 32'(e.z));
               chk("result_tag", 32'(bus.tag_out), 32'(e.tag));
               n_ret++;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_t n;
            n.z   = ref_z(bus.x, bus.y, bus.exact);
            n.tag = bus.tag_in;
            exp_q.push_back(n);
         end
      end
   end

   task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic e,
                           input logic [3:0] tg, input logic [15:0] exp_z, input string nm);
      int  lat;
      bit  seen;
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.x = a; bus.y = b; bus.exact = e; bus.tag_in = tg;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat  = 0;
      seen = 0;
      for (int c = 1; c <= 10 && !seen; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1;
            lat  = c;
         end
      end
      chk({nm, "_latency"}, 32'(lat), 32'd3);
      chk({nm, "_z"}, 32'(bus.z), 32'(exp_z));
      chk({nm, "_tag"}, 32'(bus.tag_out), 32'(tg));
   endtask

   initial begin
      logic [15:0] pz;
      logic [3:0]  pt;
      bit          pst;
      int          k, base, sent;

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.exact = 1'b0; bus.tag_in = '0;
      bus.out_ready = 1'b0;
      #3;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_z", 32'(bus.z), 32'd0);
      chk("rst_tag", 32'(bus.tag_out), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Directed cases from the datasheet.
      send_one(8'd255, 8'd255, 1'b1, 4'hA, 16'd65025, "exact_ff");
`ifdef APPROX_COMP_EN
      send_one(8'd255, 8'd255, 1'b0, 4'h3, 16'd64592, "approx_ff");
      send_one(8'h0F, 8'h01, 1'b0, 4'h5, 16'd64, "approx_drop");
`else
      send_one(8'd255, 8'd255, 1'b0, 4'h3, 16'd64528, "approx_ff");
      send_one(8'h0F, 8'h01, 1'b0, 4'h5, 16'd0, "approx_drop");
`endif
      send_one(8'h0F, 8'h01, 1'b1, 4'h6, 16'd15, "exact_small");

      // Backpressure: six back-to-back transactions with a 4-cycle consumer stall.
      repeat (4) @(negedge clk);
      base = n_ret;
      k    = 0;
      pst  = 0;
      pz   = '0;
      pt   = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge clk); #1;
         bus.out_ready = !(cyc >= 4 && cyc < 8);
         bus.in_valid  = (k < 6);
         bus.x         = 8'(k * 37 + 11);
         bus.y         = 8'(k * 53 + 7);
         bus.exact     = k[0];
         bus.tag_in    = 4'(k + 1);
         @(negedge clk);
         if (pst) begin
            chk("bp_z_stable", 32'(bus.z), 32'(pz));
            chk("bp_tag_stable", 32'(bus.tag_out), 32'(pt));
         end
         if (bus.out_valid && !bus.out_ready) chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
         pst = bus.out_valid && !bus.out_ready;
         pz  = bus.z;
         pt  = bus.tag_out;
         if (bus.in_valid && bus.in_ready) k++;
      end
      bus.in_valid = 1'b0;
      chk("bp_accepted", 32'(k), 32'd6);
      chk("bp_delivered", 32'(n_ret - base), 32'd6);

      // Asynchronous reset with two transactions in flight.
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.x = 8'd200; bus.y = 8'd199; bus.exact = 1'b1; bus.tag_in = 4'h7;
      @(posedge clk); #1;
      bus.x = 8'd123; bus.y = 8'd45; bus.exact = 1'b0; bus.tag_in = 4'h9;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_z", 32'(bus.z), 32'd0);
      chk("midrst_tag", 32'(bus.tag_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("postrst_no_stale", 32'(bus.out_valid), 32'd0);
      end
      send_one(8'd77, 8'd91, 1'b0, 4'hC, ref_z(8'd77, 8'd91, 1'b0), "postrst");

      // Random traffic with random consumer backpressure.
      sent = 0;
      for (int cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
         @(posedge clk); #1;
         bus.in_valid  = ($urandom_range(0, 7) != 0);
         bus.x         = 8'($urandom);
         bus.y         = 8'($urandom);
         bus.exact     = 1'($urandom);
         bus.tag_in    = 4'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) sent++;
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("rand_sent", 32'(sent), 32'd10000);
      chk("rand_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
